cache_victim_select: RTL and testbench
======================================

// Module: cache_victim_select
// PURPOSE
//  Runtime-selectable cache replacement engine; successor of the fixed-policy selector.
//  Tracks per-set FIFO pointers and true-LRU ages for all sets.
//  Answers victim queries with a registered 1-cycle response. Prefers invalid ways,
//  honours a per-way lock mask, and can switch policy on the fly without losing state.
//  Sits beside the I/D-cache tag arrays; the cache controller issues queries and access updates.
// PARAMETERS
//  WAY_COUNT  4        ways per set; power of two, >=2; WW=$clog2(WAY_COUNT)
//  SET_COUNT  64       sets; power of two, >=2; SW=$clog2(SET_COUNT)
//  LFSR_SEED  'h1      non-zero reset seed of the random-mode LFSR (width max(WW,4))
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high
//  mode         in   2      policy: 0 FIFO, 1 RND, 2 LRU, 3 MRU; sampled with q_valid
//  q_valid      in   1      victim query strobe
//  q_set        in   SW     set being queried
//  q_valid_ways in   WAY    per-way valid bits of q_set (from tag array)
//  lock_mask    in   WAY    1 = way excluded from replacement (global, all sets)
//  r_valid      out  1      response strobe, exactly one cycle after q_valid
//  r_way        out  WW     selected victim way
//  r_none       out  1      no replaceable way (all valid and all locked); r_way=0
//  a_valid      in   1      access update strobe (hit or fill)
//  a_set        in   SW     accessed set
//  a_way        in   WW     accessed way
//  a_fill       in   1      1 = a_way was just filled (advances FIFO pointer)
// BEHAVIOUR
//  Reset: r_valid=0, r_way=0, r_none=0; fifo_ptr[s]=0; age[s][w]=w (ages form a permutation); LFSR=LFSR_SEED.
//  Query: r_* registered from q_set state at the q_valid edge; r_valid pulses 1 cycle; back-to-back queries each cycle ok.
//  Selection order (first match wins), candidate set C = ways with lock_mask=0:
//   1) any way with q_valid_ways=0 -> lowest-index invalid way (locks ignored for invalid ways)
//   2) C empty -> r_none=1, r_way=0
//   3) FIFO: first way in C at/after fifo_ptr[q_set], wrapping modulo WAY_COUNT
//   4) RND : first way in C at/after LFSR[WW-1:0], wrapping
//   5) LRU : way in C with max age; MRU: way in C with min age; ties -> lowest index
//  Access update (a_valid): age[a_set][a_way]<=0; every other way of a_set with age < old age[a_way] increments;
//   others hold. Ages stay a permutation 0..WAY_COUNT-1. If a_fill: fifo_ptr[a_set]<=a_way+1 (wraps).
//  Ages and pointers are maintained in every mode, so a mode change takes effect on the next query with no flush.
//  Simultaneous q_valid and a_valid on the same set: response uses pre-update state; the update lands at the same edge.
//  LFSR: Galois, free-running every cycle; never reaches 0.
//  Reset mid-operation: all state returns to reset values immediately; a response pending at reset is dropped (r_valid=0).
//  Inputs are not checked; out-of-range a_way cannot occur (power-of-two WAY_COUNT).
// CONFIGURATION
//  `CACHE_WAY_LOCK_EN defined  : lock_mask honoured as above; r_none reachable.
//  `CACHE_WAY_LOCK_EN undefined: lock_mask port kept but ignored (C = all ways); r_none tied 0.
// STRUCTURE
//  Package cache_victim_pkg holds:
//   - typedef enum logic [1:0] policy_mode_t {PM_FIFO, PM_RND, PM_LRU, PM_MRU}
//   - function way_w(n) = $clog2(n)
//   - localparam for the LFSR tap table
//  Sub-module cache_victim_pick: combinational. Inputs: ages of one set, start index, candidate mask, valid mask, mode.
//   Outputs: way and none. Instantiated once on the query path.
//  Age and pointer storage: flat regs in the top module, reset asynchronously.
// TESTING  (WAY_COUNT=4, SET_COUNT=8, lock enabled unless noted)
//  1) After reset, LRU query set 3 with valid=1111, lock=0000 -> r_valid next cycle, r_way=3, r_none=0.
//  2) Accesses to set 3 ways 3,2,1,0, then LRU query -> r_way=3; MRU query -> r_way=0.
//  3) Query set 5 with valid=1011 in any mode -> r_way=2, regardless of ages or locks.
//  4) FIFO: fill ways 0,1 of set 1 (a_fill=1), lock=0100, query -> r_way=3; lock=1111 -> r_none=1, r_way=0.
//  5) Same-cycle query and access on set 2 way 3 (age 3), LRU -> r_way=3; next query -> r_way=2.
//  6) Reset asserted while q_valid high -> r_valid=0 next cycle; ages back to age[s][w]=w.
//     Build without CACHE_WAY_LOCK_EN: lock=1111 -> r_none=0, normal pick.

Source files
------------

// File: rtl/cache_victim_pkg.sv
// Shared types and constants for the cache victim selector.
//   policy_mode_t : replacement policy encoding carried on the mode port
//   way_w()       : index width for a given way count
//   LFSR_TAPS     : maximal-length Galois tap masks (right-shifting form), by width
package cache_victim_pkg;

  typedef enum logic [1:0] {PM_FIFO, PM_RND, PM_LRU, PM_MRU} policy_mode_t;

  function automatic int way_w(input int n);
    return $clog2(n);
  endfunction

  localparam int LFSR_MIN_W = 4;
  localparam int LFSR_MAX_W = 16;

  localparam logic [15:0] LFSR_TAPS [LFSR_MIN_W:LFSR_MAX_W] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  // The random-mode LFSR is never narrower than 4 bits so it has a useful period.
  function automatic int lfsr_w(input int ww);
    return (ww > LFSR_MIN_W) ? ww : LFSR_MIN_W;
  endfunction

endpackage

// File: rtl/cache_victim_pick.sv
// Combinational victim chooser for one set.
//   ages_i  : packed per-way ages (way w at [w*WW +: WW]), 0 = most recent
//   start_i : scan origin for FIFO / RND
//   cand_i  : 1 = way may be replaced
//   valid_i : per-way valid bits; an invalid way always wins
//   mode_i  : policy_mode_t encoding
//   way_o   : chosen way
//   none_o  : all ways valid and no candidate; way_o is 0
module cache_victim_pick
  import cache_victim_pkg::*;
#(
  parameter int WAY_COUNT = 4,
  localparam int WW = way_w(WAY_COUNT)
) (
  input  logic [WAY_COUNT*WW-1:0] ages_i,
  input  logic [WW-1:0]           start_i,
  input  logic [WAY_COUNT-1:0]    cand_i,
  input  logic [WAY_COUNT-1:0]    valid_i,
  input  logic [1:0]              mode_i,
  output logic [WW-1:0]           way_o,
  output logic                    none_o
);

  logic          found;
  logic [WW-1:0] best;
  logic [WW-1:0] idx;
  logic [WW-1:0] age;

  always_comb begin
    way_o  = '0;
    none_o = 1'b0;
    found  = 1'b0;
    best   = '0;
    idx    = '0;
    age    = '0;
    if (!(&valid_i)) begin
      // Invalid ways ignore the lock mask: filling them costs nothing.
      for (int i = 0; i < WAY_COUNT; i++) begin
        if (!valid_i[i] && !found) begin
          way_o = WW'(i);
          found = 1'b1;
        end
      end
    end else if (cand_i == '0) begin
      none_o = 1'b1;
    end else begin
      case (mode_i)
        PM_FIFO, PM_RND: begin
          // WW-bit addition wraps modulo WAY_COUNT for free.
          for (int i = 0; i < WAY_COUNT; i++) begin
            idx = start_i + WW'(i);
            if (cand_i[idx] && !found) begin
              way_o = idx;
              found = 1'b1;
            end
          end
        end
        PM_LRU: begin
          for (int i = 0; i < WAY_COUNT; i++) begin
            age = ages_i[i*WW +: WW];
            if (cand_i[i] && (!found || age > best)) begin
              way_o = WW'(i);
              best  = age;
              found = 1'b1;
            end
          end
        end
        default: begin
          for (int i = 0; i < WAY_COUNT; i++) begin
            age = ages_i[i*WW +: WW];
            if (cand_i[i] && (!found || age < best)) begin
              way_o = WW'(i);
              best  = age;
              found = 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cache_victim_select.sv
// Runtime-selectable cache replacement engine (FIFO / random / LRU / MRU).
// Keeps per-set FIFO pointers and true-LRU ages for every set in all modes, so
// the policy can change between queries without a flush. Victim queries get a
// registered response one cycle later.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   mode              : policy, sampled with q_valid
//   q_valid/q_set/q_valid_ways/lock_mask : victim query
//   r_valid/r_way/r_none                 : registered response
//   a_valid/a_set/a_way/a_fill           : access (hit or fill) update
// Build option: define CACHE_WAY_LOCK_EN to honour lock_mask; otherwise the
// port is ignored and r_none stays 0.
module cache_victim_select
  import cache_victim_pkg::*;
#(
  parameter int          WAY_COUNT = 4,
  parameter int          SET_COUNT = 64,
  parameter logic [31:0] LFSR_SEED = 32'h1,
  localparam int WW = way_w(WAY_COUNT),
  localparam int SW = $clog2(SET_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 q_valid,
  input  logic [SW-1:0]        q_set,
  input  logic [WAY_COUNT-1:0] q_valid_ways,
  input  logic [WAY_COUNT-1:0] lock_mask,
  output logic                 r_valid,
  output logic [WW-1:0]        r_way,
  output logic                 r_none,
  input  logic                 a_valid,
  input  logic [SW-1:0]        a_set,
  input  logic [WW-1:0]        a_way,
  input  logic                 a_fill
);

  localparam int            LW   = lfsr_w(WW);
  localparam logic [LW-1:0] TAPS = LW'(LFSR_TAPS[LW]);
  localparam logic [LW-1:0] SEED = LFSR_SEED[LW-1:0];

  logic [WW-1:0]           age_q [SET_COUNT][WAY_COUNT];
  logic [WW-1:0]           fifo_ptr_q [SET_COUNT];
  logic [WW-1:0]           age_row_d [WAY_COUNT];
  logic [WW-1:0]           old_age;
  logic [LW-1:0]           lfsr_q, lfsr_d;
  logic                    r_valid_q;
  logic [WW-1:0]           r_way_q, r_way_d;
  logic                    r_none_q, r_none_d;
  logic [WAY_COUNT*WW-1:0] q_ages;
  logic [WW-1:0]           q_start;
  logic [WAY_COUNT-1:0]    cand;
  logic                    pick_none;

  // Galois LFSR: a non-zero state never maps to zero.
  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // Recency update: the accessed way becomes age 0, ways that were more recent
  // than it shift back by one, older ways are untouched.
  always_comb begin
    old_age = age_q[a_set][a_way];
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (WW'(w) == a_way)
        age_row_d[w] = '0;
      else if (age_q[a_set][w] < old_age)
        age_row_d[w] = age_q[a_set][w] + 1'b1;
      else
        age_row_d[w] = age_q[a_set][w];
    end
  end

  always_comb begin
    q_ages = '0;
    for (int w = 0; w < WAY_COUNT; w++)
      q_ages[w*WW +: WW] = age_q[q_set][w];
  end

  assign q_start = (mode == PM_FIFO) ? fifo_ptr_q[q_set] : lfsr_q[WW-1:0];

`ifdef CACHE_WAY_LOCK_EN
  assign cand     = ~lock_mask;
  assign r_none_d = pick_none;
`else
  logic unused_cfg;
  assign cand       = '1;
  assign r_none_d   = 1'b0;
  assign unused_cfg = ^{lock_mask, pick_none};
`endif

  cache_victim_pick #(
    .WAY_COUNT(WAY_COUNT)
  ) u_pick (
    .ages_i (q_ages),
    .start_i(q_start),
    .cand_i (cand),
    .valid_i(q_valid_ways),
    .mode_i (mode),
    .way_o  (r_way_d),
    .none_o (pick_none)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        fifo_ptr_q[s] <= '0;
        for (int w = 0; w < WAY_COUNT; w++)
          age_q[s][w] <= WW'(w);
      end
      lfsr_q    <= SEED;
      r_valid_q <= 1'b0;
      r_way_q   <= '0;
      r_none_q  <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      r_valid_q <= q_valid;
      // Query reads the pre-update state even when an access hits the same set.
      if (q_valid) begin
        r_way_q  <= r_way_d;
        r_none_q <= r_none_d;
      end
      if (a_valid) begin
        for (int w = 0; w < WAY_COUNT; w++)
          age_q[a_set][w] <= age_row_d[w];
        if (a_fill)
          fifo_ptr_q[a_set] <= a_way + 1'b1;
      end
    end
  end

  assign r_valid = r_valid_q;
  assign r_way   = r_way_q;
  assign r_none  = r_none_q;

endmodule

// File: tb/tb_cache_victim_select.sv
module tb_cache_victim_select;

  localparam int NW = 4;
  localparam int NS = 8;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic       q_valid;
  logic [2:0] q_set;
  logic [3:0] q_valid_ways;
  logic [3:0] lock_mask;
  logic       r_valid;
  logic [1:0] r_way;
  logic       r_none;
  logic       a_valid;
  logic [2:0] a_set;
  logic [1:0] a_way;
  logic       a_fill;

  int checks;
  int errors;

  // Reference state: ord[s][0] is the most recently used way of set s,
  // ord[s][NW-1] the least recently used.
  int ord [NS][NW];
  int fptr [NS];
  int lf;

  cache_victim_select #(
    .WAY_COUNT(NW),
    .SET_COUNT(NS),
    .LFSR_SEED(32'h1)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .q_valid(q_valid), .q_set(q_set), .q_valid_ways(q_valid_ways), .lock_mask(lock_mask),
    .r_valid(r_valid), .r_way(r_way), .r_none(r_none),
    .a_valid(a_valid), .a_set(a_set), .a_way(a_way), .a_fill(a_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      fptr[s] = 0;
      for (int p = 0; p < NW; p++) ord[s][p] = p;
    end
    lf = 1;
  endtask

  task automatic model_access(input int s, input int w, input bit fill);
    int p;
    p = 0;
    for (int i = 0; i < NW; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
    if (fill) fptr[s] = (w + 1) % NW;
  endtask

  task automatic model_pick(input int m, input int s, input logic [3:0] v, input logic [3:0] lk,
                            output int way, output bit none);
    logic [3:0] cand;
    int start;
    bit done;
    way = 0; none = 0; done = 0;
`ifdef CACHE_WAY_LOCK_EN
    cand = ~lk;
`else
    cand = 4'hF;
`endif
    for (int w = 0; w < NW; w++)
      if (!v[w] && !done) begin way = w; done = 1; end
    if (!done) begin
      if (cand == 4'h0) begin
        none = 1; done = 1;
      end else if (m == 0 || m == 1) begin
        start = (m == 0) ? fptr[s] : (lf % NW);
        for (int k = 0; k < NW; k++)
          if (cand[(start + k) % NW] && !done) begin way = (start + k) % NW; done = 1; end
      end else if (m == 2) begin
        for (int p = NW - 1; p >= 0; p--)
          if (cand[ord[s][p]] && !done) begin way = ord[s][p]; done = 1; end
      end else begin
        for (int p = 0; p < NW; p++)
          if (cand[ord[s][p]] && !done) begin way = ord[s][p]; done = 1; end
      end
    end
  endtask

  // One clock: predict from pre-edge model state, advance the model, check after the edge.
  task automatic tick();
    int  ew;
    bit  en;
    bit  qv;
    qv = q_valid;
    ew = 0; en = 0;
    if (qv) model_pick(int'(mode), int'(q_set), q_valid_ways, lock_mask, ew, en);
    if (a_valid) model_access(int'(a_set), int'(a_way), a_fill);
    lf = (lf >> 1) ^ (((lf & 1) != 0) ? 'hC : 0);
    @(posedge clk);
    #1;
    chk("r_valid", r_valid, qv);
    if (qv) begin
      chk("r_way", r_way, ew);
      chk("r_none", r_none, en);
    end
  endtask

  task automatic query(input int m, input int s, input logic [3:0] v, input logic [3:0] lk);
    mode = m[1:0]; q_set = s[2:0]; q_valid_ways = v; lock_mask = lk;
    q_valid = 1'b1; a_valid = 1'b0;
    tick();
    q_valid = 1'b0;
  endtask

  task automatic access(input int s, input int w, input bit fill);
    a_set = s[2:0]; a_way = w[1:0]; a_fill = fill;
    a_valid = 1'b1; q_valid = 1'b0;
    tick();
    a_valid = 1'b0; a_fill = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; mode = 2'd0; q_valid = 1'b0; q_set = '0; q_valid_ways = 4'hF;
    lock_mask = 4'h0; a_valid = 1'b0; a_set = '0; a_way = '0; a_fill = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_way", r_way, 0);
    chk("rst_r_none", r_none, 0);
    reset = 1'b0;

    // 1) fresh ages: LRU of set 3 is way 3
    query(2, 3, 4'hF, 4'h0);
    chk("t1_way", r_way, 3);

    // 2) touch 3,2,1,0 -> way 3 least recent, way 0 most recent
    for (int w = 3; w >= 0; w--) access(3, w, 1'b0);
    query(2, 3, 4'hF, 4'h0);
    chk("t2_lru", r_way, 3);
    query(3, 3, 4'hF, 4'h0);
    chk("t2_mru", r_way, 0);

    // 3) invalid way wins in every mode, even when locked
    for (int m = 0; m < 4; m++) begin
      query(m, 5, 4'b1011, 4'hF);
      chk("t3_way", r_way, 2);
      chk("t3_none", r_none, 0);
    end

    // 4) FIFO pointer after fills of ways 0,1 is 2
    access(1, 0, 1'b1);
    access(1, 1, 1'b1);
`ifdef CACHE_WAY_LOCK_EN
    query(0, 1, 4'hF, 4'b0100);
    chk("t4_locked_skip", r_way, 3);
    query(0, 1, 4'hF, 4'hF);
    chk("t4_none", r_none, 1);
    chk("t4_none_way", r_way, 0);
`else
    query(0, 1, 4'hF, 4'hF);
    chk("t4_nolock_way", r_way, 2);
    chk("t4_nolock_none", r_none, 0);
`endif

    // 5) query and access on the same set in one cycle: response sees old ages
    mode = 2'd2; q_set = 3'd2; q_valid_ways = 4'hF; lock_mask = 4'h0; q_valid = 1'b1;
    a_valid = 1'b1; a_set = 3'd2; a_way = 2'd3; a_fill = 1'b0;
    tick();
    chk("t5_same_cycle", r_way, 3);
    q_valid = 1'b0; a_valid = 1'b0;
    query(2, 2, 4'hF, 4'h0);
    chk("t5_after", r_way, 2);

    // 6) reset with a response pending and a query in flight
    mode = 2'd2; q_set = 3'd2; q_valid_ways = 4'hF; lock_mask = 4'h0; q_valid = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_drop", r_valid, 0);
    @(posedge clk);
    #1;
    chk("t6_held", r_valid, 0);
    model_reset();
    reset = 1'b0;
    q_valid = 1'b0;
    query(2, 2, 4'hF, 4'h0);
    chk("t6_ages_reset", r_way, 3);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      q_valid      = ($urandom_range(0, 2) != 0);
      mode         = 2'($urandom_range(0, 3));
      q_set        = 3'($urandom_range(0, NS - 1));
      q_valid_ways = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      lock_mask    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      a_valid      = ($urandom_range(0, 1) != 0);
      a_set        = ($urandom_range(0, 3) == 0) ? q_set : 3'($urandom_range(0, NS - 1));
      a_way        = 2'($urandom_range(0, NW - 1));
      a_fill       = ($urandom_range(0, 1) != 0);
      tick();
    end
    q_valid = 1'b0; a_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
